shared_net_arbiter: RTL and testbench

SHARED_NET_ARBITER -- requirements
Module: shared_net_arbiter

---
 rtl/shared_net_arbiter.sv | 139 +++++++++++++
 tb/tb_shared_net_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_net_arbiter.sv
// Round-robin ownership arbiter for a shared net: one-hot grant, forced
// revocation after MAX_HOLD cycles and TA_CYC idle cycles between owners.
module shared_net_arbiter #(
  parameter int NREQ     = 20,
  parameter int MAX_HOLD = 15,
  parameter int TA_CYC   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [4:0]      gnt_id,
  output logic            gnt_vld,
  output logic            drv_en,
  output logic            revoke,
  output logic [7:0]      busy_cnt
);

  // state | meaning
  // IDLE  | no owner, waiting for any request
  // GRANT | one requester owns the net, hold counter running
  // TURN  | net released, TA_CYC idle cycles before the next owner
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      ptr_q, ptr_d;
  logic [7:0]      hold_q, hold_d;
  logic [1:0]      turn_q, turn_d;
  logic            armed_q;
  logic [NREQ-1:0] gnt_d;
  logic [4:0]      gnt_id_d;
  logic            gnt_vld_d;
  logic            revoke_d;
  logic [7:0]      busy_d;
  logic [4:0]      win_id;
  logic            win_vld;
  logic [4:0]      cand;
  logic            owner_req;
  logic            take;

  assign owner_req = |(req & gnt);

  // First set request searching upward from the last owner, wrapping.
  always_comb begin
    win_id  = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = 5'((int'(ptr_q) + i) % NREQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    turn_d    = turn_q;
    gnt_d     = gnt;
    gnt_id_d  = gnt_id;
    gnt_vld_d = gnt_vld;
    revoke_d  = 1'b0;
    busy_d    = busy_cnt;
    take      = 1'b0;
    case (state_q)
      IDLE: take = armed_q && win_vld;
      GRANT: begin
        if (!owner_req || hold_q == 8'(MAX_HOLD)) begin
          state_d   = TURN;
          turn_d    = 2'(TA_CYC);
          hold_d    = '0;
          gnt_d     = '0;
          gnt_vld_d = 1'b0;
          // a release in the expiry cycle wins: only a still-held grant is revoked
          if (owner_req) begin
            revoke_d = 1'b1;
            if (busy_cnt != 8'hFF) busy_d = busy_cnt + 8'd1;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      TURN: begin
        if (turn_q == 2'd1) begin
          state_d = IDLE;
          take    = win_vld;
        end else begin
          turn_d = turn_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      state_d   = GRANT;
      ptr_d     = win_id;
      hold_d    = 8'd1;
      gnt_d     = {{(NREQ-1){1'b0}}, 1'b1} << win_id;
      gnt_id_d  = win_id;
      gnt_vld_d = 1'b1;
    end
  end

  // armed_q holds off the first grant until the second edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= 5'(NREQ - 1);
      hold_q   <= '0;
      turn_q   <= '0;
      armed_q  <= 1'b0;
      gnt      <= '0;
      gnt_id   <= '0;
      gnt_vld  <= 1'b0;
      drv_en   <= 1'b0;
      revoke   <= 1'b0;
      busy_cnt <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      turn_q   <= turn_d;
      armed_q  <= 1'b1;
      gnt      <= gnt_d;
      gnt_id   <= gnt_id_d;
      gnt_vld  <= gnt_vld_d;
      drv_en   <= gnt_vld_d;
      revoke   <= revoke_d;
      busy_cnt <= busy_d;
    end
  end

endmodule

// File: tb/tb_shared_net_arbiter.sv
// Bench for shared_net_arbiter: directed scenarios with literal expectations
// plus random traffic checked every cycle against an owner/gap model.
module tb_shared_net_arbiter;
  localparam int N     = 20;
  localparam int MH    = 15;
  localparam int TA    = 2;
  localparam int BOUND = (N - 1) * (MH + TA);

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req   = '0;
  logic [N-1:0] gnt;
  logic [4:0]   gnt_id;
  logic         gnt_vld;
  logic         drv_en;
  logic         revoke;
  logic [7:0]   busy_cnt;

  int checks   = 0;
  int failures = 0;

  shared_net_arbiter #(.NREQ(N), .MAX_HOLD(MH), .TA_CYC(TA)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .gnt_vld  (gnt_vld),
    .drv_en   (drv_en),
    .revoke   (revoke),
    .busy_cnt (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Model: who owns the net, how long they have held it, idle cycles still owed.
  int m_owner;
  int m_held;
  int m_gap;
  int m_ptr;
  int m_busy;
  bit m_rev;
  bit m_armed;

  function automatic void model_reset();
    m_owner = -1;
    m_held  = 0;
    m_gap   = 0;
    m_ptr   = N - 1;
    m_busy  = 0;
    m_rev   = 1'b0;
    m_armed = 1'b0;
  endfunction

  function automatic void model_pick();
    for (int j = 1; j <= N; j++) begin
      if (req[(m_ptr + j) % N]) begin
        m_owner = (m_ptr + j) % N;
        m_ptr   = m_owner;
        m_held  = 1;
        return;
      end
    end
  endfunction

  function automatic void model_step();
    m_rev = 1'b0;
    if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_owner = -1;
        m_gap   = TA;
      end else if (m_held == MH) begin
        m_owner = -1;
        m_gap   = TA;
        m_rev   = 1'b1;
        if (m_busy < 255) m_busy++;
      end else begin
        m_held++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) model_pick();
    end else if (m_armed) begin
      model_pick();
    end
    m_armed = 1'b1;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle compare plus overlap / starvation monitors during random traffic.
  bit mon_on = 1'b0;
  int wait_cyc[N];
  int max_wait = 0;
  int low_run  = 0;
  bit prev_vld = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      check("gnt", gnt, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("gnt_vld", gnt_vld, (m_owner >= 0) ? 32'd1 : 32'd0);
      check("drv_en", drv_en, (m_owner >= 0) ? 32'd1 : 32'd0);
      check("revoke", revoke, m_rev);
      check("busy_cnt", busy_cnt, m_busy);
      if (m_owner >= 0) check("gnt_id", gnt_id, m_owner);
      check("gnt_onehot0", $onehot0(gnt), 1);
      if (mon_on) begin
        for (int i = 0; i < N; i++) begin
          if (req[i] && !gnt[i]) wait_cyc[i]++;
          else wait_cyc[i] = 0;
          if (wait_cyc[i] > max_wait) max_wait = wait_cyc[i];
        end
        if (gnt_vld && !prev_vld) check("turnaround_gap_ok", (low_run >= TA) ? 1 : 0, 1);
      end else begin
        for (int i = 0; i < N; i++) wait_cyc[i] = 0;
      end
      low_run  = gnt_vld ? 0 : low_run + 1;
      prev_vld = gnt_vld;
    end
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    req   = '0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  int          order[$];
  int          lens[$];
  int          run;
  bit          pv;
  logic [31:0] busy_at_21;
  int          n_g;
  int          n_r;
  int          first_rise;
  int          first_id;

  initial begin
    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_gnt_id", gnt_id, 0);
    check("rst_gnt_vld", gnt_vld, 0);
    check("rst_drv_en", drv_en, 0);
    check("rst_revoke", revoke, 0);
    check("rst_busy_cnt", busy_cnt, 0);

    // all requesters from reset: no grant on first edge, then 0..19,0
    @(posedge clk);
    #1;
    req   = '1;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("first_edge_no_grant", gnt_vld, 0);
    run        = 0;
    pv         = 1'b0;
    busy_at_21 = '1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (gnt_vld && !pv) begin
        order.push_back(gnt_id);
        if (order.size() == 21) busy_at_21 = busy_cnt;
      end
      if (gnt_vld) run++;
      else if (pv) begin
        lens.push_back(run);
        run = 0;
      end
      pv = gnt_vld;
    end
    for (int k = 0; k < 21; k++)
      check($sformatf("sweep_order_%0d", k), (k < order.size()) ? order[k] : -1, k % N);
    for (int k = 0; k < 20; k++)
      check($sformatf("sweep_len_%0d", k), (k < lens.size()) ? lens[k] : -1, MH);
    check("sweep_busy_after_20", busy_at_21, 20);

    // single request of 4 cycles
    do_reset();
    req = 20'h00020;
    n_g = 0;
    n_r = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 3) req = '0;
      @(negedge clk);
      if (k == 0) begin
        check("single_first_gnt", gnt, 32'h20);
        check("single_first_id", gnt_id, 5);
      end
      if (gnt == 20'h00020) n_g++;
      if (revoke) n_r++;
    end
    check("single_gnt_cycles", n_g, 4);
    check("single_no_revoke", n_r, 0);
    check("single_idle_after", gnt_vld, 0);

    // release in the same cycle the hold count reaches MAX_HOLD
    req = 20'h00080;
    n_g = 0;
    n_r = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (k == 14) req = '0;
      @(negedge clk);
      if (gnt_vld) n_g++;
      if (revoke) n_r++;
    end
    check("tie_gnt_cycles", n_g, 15);
    check("tie_no_revoke", n_r, 0);
    check("tie_busy_unchanged", busy_cnt, 0);

    // held one cycle longer: expiry revokes
    req = 20'h00080;
    n_g = 0;
    n_r = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (k == 15) req = '0;
      @(negedge clk);
      if (gnt_vld) n_g++;
      if (revoke) n_r++;
    end
    check("expire_gnt_cycles", n_g, 15);
    check("expire_revoke", n_r, 1);
    check("expire_busy", busy_cnt, 1);

    // wrap-around from ptr=18 with requests {2,19}
    req = 20'h40000;
    tick();
    req = 20'h80004;
    order.delete();
    pv = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (gnt_vld && !pv) order.push_back(gnt_id);
      pv = gnt_vld;
    end
    check("wrap_0", (order.size() > 0) ? order[0] : -1, 18);
    check("wrap_1", (order.size() > 1) ? order[1] : -1, 19);
    check("wrap_2", (order.size() > 2) ? order[2] : -1, 2);

    // reset in the third grant cycle, then order restarts at 0
    req = '0;
    repeat (30) tick();
    req = 20'h00200;
    tick();
    req = '0;
    repeat (6) tick();
    req = '1;
    tick();
    @(negedge clk);
    check("pre_rst_owner", gnt_id, 10);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt", gnt, 0);
    check("async_rst_drv_en", drv_en, 0);
    check("async_rst_revoke", revoke, 0);
    tick();
    rst_n      = 1'b1;
    first_rise = -1;
    first_id   = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (gnt_vld && first_rise < 0) begin
        first_rise = c;
        first_id   = gnt_id;
      end
    end
    check("post_rst_first_id", first_id, 0);
    check("post_rst_first_edge", first_rise, 2);

    // random traffic
    do_reset();
    mon_on = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      tick();
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 15) == 0) req[i] = ~req[i];
    end
    mon_on = 1'b0;
    check("starvation_bound_ok", (max_wait <= BOUND) ? 1 : 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
